// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and default widths for the unified-memory arbiter
// Contents:
//   state_t   - arbiter FSM states IDLE/BUSY/RESP
//   owner_t   - current bus owner OWN_I (fetch) / OWN_D (load/store)
//   DEF_AW    - default address width
//   DEF_DW    - default data width
//   STARVE_W  - width of the fetch starvation counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int DEF_AW   = 16;
    localparam int DEF_DW   = 32;
    localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of data grants made while a fetch is waiting
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc       - a data grant was made while the fetch port is requesting
//   clr       - fetch granted or fetch not requesting; clear wins over inc
//   max       - saturation value
//   at_max    - count has reached max, fetch must win the next grant
module arb_starve_ctr
    import mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    input  logic [STARVE_W-1:0] max,
    output logic                at_max
);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    assign at_max = cnt_q >= max;
    assign cnt_d  = clr ? '0 : (inc & ~at_max) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction and data ports
// Ports:
//   clk, rst                           - clock, asynchronous active-high reset
//   imem_req/addr                      - fetch request, held until imem_ready
//   imem_data_out, imem_ready          - registered fetch data, ready level
//   dmem_req/wr/addr/data_in           - load/store request, held until dmem_ready
//   dmem_data_out, dmem_ready          - registered load data, ready level
//   mem_en/wr/addr/wdata               - registered request to the memory
//   mem_rdata, mem_done                - memory response, one-cycle done pulse
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imem_req,
    input  logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_data_out,
    output logic          imem_ready,
    input  logic          dmem_req,
    input  logic          dmem_wr,
    input  logic [AW-1:0] dmem_addr,
    input  logic [DW-1:0] dmem_data_in,
    output logic [DW-1:0] dmem_data_out,
    output logic          dmem_ready,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done
);

    state_t        state_q;
    owner_t        owner_q;
    logic          mem_en_q;
    logic          mem_wr_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] imem_data_q;
    logic [DW-1:0] dmem_data_q;
    logic          at_max;
    logic          grant_i;
    logic          grant_d;

    // Data wins unless the fetch has waited through STARVE_MAX data grants.
    assign grant_i = (state_q == IDLE) & imem_req & (~dmem_req | at_max);
    assign grant_d = (state_q == IDLE) & dmem_req & ~grant_i;

    arb_starve_ctr u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (grant_d & imem_req),
        .clr    (grant_i | ~imem_req),
        .max    (STARVE_W'(STARVE_MAX)),
        .at_max (at_max)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_D;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            imem_data_q <= '0;
            dmem_data_q <= '0;
        end else begin
            case (state_q)
                IDLE:
                    if (grant_i | grant_d) begin
                        state_q     <= BUSY;
                        owner_q     <= grant_i ? OWN_I : OWN_D;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= grant_d & dmem_wr;
                        mem_addr_q  <= grant_i ? imem_addr : dmem_addr;
                        mem_wdata_q <= grant_i ? '0 : dmem_data_in;
                    end
                BUSY:
                    if (mem_done) begin
                        state_q  <= RESP;
                        mem_en_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        // Stores leave the load data register untouched.
                        if (!mem_wr_q && owner_q == OWN_I) imem_data_q <= mem_rdata;
                        if (!mem_wr_q && owner_q == OWN_D) dmem_data_q <= mem_rdata;
                    end
                // No grant in RESP, so a still-held request is not served twice.
                default: state_q <= IDLE;
            endcase
        end

    assign imem_ready    = ~imem_req | (state_q == RESP && owner_q == OWN_I);
    assign dmem_ready    = ~dmem_req | (state_q == RESP && owner_q == OWN_D);
    assign imem_data_out = imem_data_q;
    assign dmem_data_out = dmem_data_q;
    assign mem_en        = mem_en_q;
    assign mem_wr        = mem_wr_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_data_out;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_wr;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;
    logic        dmem_ready;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(16), .DW(32), .STARVE_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_data_out (imem_data_out),
        .imem_ready    (imem_ready),
        .dmem_req      (dmem_req),
        .dmem_wr       (dmem_wr),
        .dmem_addr     (dmem_addr),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out),
        .dmem_ready    (dmem_ready),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_done      (mem_done)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req = 0; imem_addr = 0; dmem_req = 0; dmem_wr = 0;
        dmem_addr = 0; dmem_data_in = 0; mem_rdata = 0; mem_done = 0;
        step(); step();
        checks++;
        if (mem_en !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: en=%b wr=%b addr=%h wdata=%h, expected 0 0 0000 00000000", mem_en, mem_wr, mem_addr, mem_wdata);
        end
        checks++;
        if (imem_data_out !== 32'h0 || dmem_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: i=%h d=%h, expected 0 0", imem_data_out, dmem_data_out);
        end
        checks++;
        if (imem_ready !== 1'b1 || dmem_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_idle: i=%b d=%b, expected 1 1", imem_ready, dmem_ready);
        end
        imem_req = 1'b1;
        #1;
        checks++;
        if (imem_ready !== 1'b0 || dmem_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_req: i=%b d=%b, expected 0 1", imem_ready, dmem_ready);
        end
        imem_req = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        step();
        imem_req = 1; imem_addr = 16'h0010; mem_rdata = 32'hDEADBEEF;
        step();
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0010 || mem_wr !== 1'b0 || imem_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_issue: en=%b addr=%h wr=%b rdy=%b, expected 1 0010 0 0", mem_en, mem_addr, mem_wr, imem_ready);
        end
        mem_done = 1;
        step();
        mem_done = 0;
        checks++;
        if (imem_ready !== 1'b1 || imem_data_out !== 32'hDEADBEEF || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp: rdy=%b data=%h en=%b, expected 1 deadbeef 0", imem_ready, imem_data_out, mem_en);
        end
        imem_req = 0;
        step();
        checks++;
        if (mem_en !== 1'b0 || imem_ready !== 1'b1 || dmem_ready !== 1'b1) begin
            errors++;
            $display("FAIL fetch_idle: en=%b irdy=%b drdy=%b, expected 0 1 1", mem_en, imem_ready, dmem_ready);
        end
    endtask

    task automatic test_simultaneous();
        imem_req = 1; imem_addr = 16'h0004;
        dmem_req = 1; dmem_wr = 1; dmem_addr = 16'h0100; dmem_data_in = 32'h1234;
        mem_rdata = 32'h1111_2222;
        step();
        checks++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL simul_d_first: en=%b wr=%b addr=%h wdata=%h, expected 1 1 0100 00001234", mem_en, mem_wr, mem_addr, mem_wdata);
        end
        step();
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0100 || dmem_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_hold: en=%b addr=%h drdy=%b, expected 1 0100 0", mem_en, mem_addr, dmem_ready);
        end
        mem_done = 1;
        step();
        mem_done = 0;
        checks++;
        if (dmem_ready !== 1'b1 || imem_ready !== 1'b0 || dmem_data_out !== 32'h0) begin
            errors++;
            $display("FAIL simul_d_resp: drdy=%b irdy=%b ddata=%h, expected 1 0 00000000", dmem_ready, imem_ready, dmem_data_out);
        end
        dmem_req = 0; dmem_wr = 0;
        step();
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL simul_gap: en=%b, expected 0", mem_en);
        end
        step();
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0004 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL simul_i_issue: en=%b addr=%h wr=%b, expected 1 0004 0", mem_en, mem_addr, mem_wr);
        end
        step();
        mem_done = 1;
        step();
        mem_done = 0;
        checks++;
        if (imem_ready !== 1'b1 || imem_data_out !== 32'h1111_2222) begin
            errors++;
            $display("FAIL simul_i_resp: rdy=%b data=%h, expected 1 11112222", imem_ready, imem_data_out);
        end
        imem_req = 0;
        step();
    endtask

    task automatic test_starvation();
        imem_req = 1; imem_addr = 16'h0200;
        dmem_req = 1; dmem_wr = 0; dmem_addr = 16'h0300;
        for (int g = 0; g < 6; g++) begin
            int n = 0;
            logic [15:0] exp_addr;
            exp_addr = (g == 4) ? 16'h0200 : 16'h0300;
            while (mem_en !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            checks++;
            if (n >= 10 || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL starve_grant%0d: waited=%0d addr=%h, expected <10 %h", g, n, mem_addr, exp_addr);
            end
            mem_rdata = (g == 5) ? 32'h0000_6000 : 32'h0000_5000 + 32'(g);
            mem_done = 1;
            step();
            mem_done = 0;
            if (g == 4) imem_addr = 16'h0204;
            if (g == 5) begin
                imem_req = 0;
                dmem_req = 0;
            end
        end
        checks++;
        if (imem_data_out !== 32'h0000_5004 || dmem_data_out !== 32'h0000_6000) begin
            errors++;
            $display("FAIL starve_data: i=%h d=%h, expected 00005004 00006000", imem_data_out, dmem_data_out);
        end
        step();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 3; c++) begin
            mem_rdata = 32'hBAD0_BAD0;
            mem_done = (c == 1);
            step();
            checks++;
            if (imem_ready !== 1'b1 || dmem_ready !== 1'b1 || mem_en !== 1'b0 ||
                imem_data_out !== 32'h0000_5004 || dmem_data_out !== 32'h0000_6000) begin
                errors++;
                $display("FAIL idle_%0d: irdy=%b drdy=%b en=%b i=%h d=%h, expected 1 1 0 00005004 00006000",
                         c, imem_ready, dmem_ready, mem_en, imem_data_out, dmem_data_out);
            end
        end
        mem_done = 0;
    endtask

    task automatic test_store_keeps_load();
        dmem_req = 1; dmem_wr = 0; dmem_addr = 16'h0080; mem_rdata = 32'hCAFEF00D;
        step();
        mem_done = 1;
        step();
        mem_done = 0;
        checks++;
        if (dmem_ready !== 1'b1 || dmem_data_out !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL load_resp: rdy=%b data=%h, expected 1 cafef00d", dmem_ready, dmem_data_out);
        end
        dmem_req = 0;
        step();
        dmem_req = 1; dmem_wr = 1; dmem_addr = 16'h0084; dmem_data_in = 32'h77; mem_rdata = 32'h9999_9999;
        step();
        checks++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_wdata !== 32'h77) begin
            errors++;
            $display("FAIL store_issue: en=%b wr=%b wdata=%h, expected 1 1 00000077", mem_en, mem_wr, mem_wdata);
        end
        mem_done = 1;
        step();
        mem_done = 0;
        checks++;
        if (dmem_ready !== 1'b1 || dmem_data_out !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL store_keeps_load: rdy=%b data=%h, expected 1 cafef00d", dmem_ready, dmem_data_out);
        end
        dmem_req = 0; dmem_wr = 0;
        step();
    endtask

    task automatic test_reset_mid();
        imem_req = 1; imem_addr = 16'h0040;
        step();
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL mid_issue: en=%b addr=%h, expected 1 0040", mem_en, mem_addr);
        end
        rst = 1;
        #1;
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== 16'h0 || imem_data_out !== 32'h0 || dmem_data_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_async: en=%b addr=%h i=%h d=%h, expected 0 0000 0 0", mem_en, mem_addr, imem_data_out, dmem_data_out);
        end
        step();
        rst = 0;
        imem_req = 0;
        mem_rdata = 32'h1234_5678;
        mem_done = 1;
        step();
        mem_done = 0;
        step();
        checks++;
        if (mem_en !== 1'b0 || imem_data_out !== 32'h0 || imem_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_late_done: en=%b i=%h rdy=%b, expected 0 0 1", mem_en, imem_data_out, imem_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_idle();
        test_store_keeps_load();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
